mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 64-bit-wide synchronous RAM between the fetch stage (I port, 32-bit instruction reads) and the memory stage (D port, RV64 loads and stores).
- Replaces the separate instruction and data memories.
- Performs D-side byte-lane alignment: write strobes, write-data replication, and read extraction with sign or zero extension.
- Pipeline stall logic consumes `i_gnt` and `d_gnt` to derive StallF and the memory-stage stall.

Parameters:
- ADDR_W, 16, byte-address width on both requester ports.
- STARVE_MAX, 4, consecutive denied I-port cycles after which the I port wins arbitration.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid; one cycle after i_gnt
- i_rdata  out  32  instruction word
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_func3  in  3  RISC-V funct3 size/sign code
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data, right-aligned
- d_gnt  out  1  D request consumed this cycle (combinational)
- d_rvalid  out  1  load data valid; one cycle after d_gnt
- d_rdata  out  64  extended load data
- d_err  out  1  misaligned or illegal access; one-cycle pulse, one cycle after d_gnt
- mem_en  out  1  RAM enable
- mem_we  out  8  RAM byte write strobes
- mem_addr  out  ADDR_W-3  RAM doubleword index, equal to the granted address bits [ADDR_W-1:3]
- mem_wdata  out  64  lane-replicated store data
- mem_rdata  in  64  RAM read data; valid one cycle after mem_en with mem_we = 0

Behaviour:
- Reset (reset = 0, asynchronous): response owner cleared, starve counter = 0.
  - i_rvalid, d_rvalid, d_err = 0; i_rdata and d_rdata = 0.
  - While reset is held, i_gnt, d_gnt, mem_en and mem_we are forced to 0.
  - Reset asserted while a read is outstanding discards that response; no rvalid follows.
- Legality of a D request:
  - Legal: func3 in {0,1,2,3,4,5,6} for loads, {0,1,2,3} for stores, with the address aligned to the access size (half: addr[0] = 0, word: addr[1:0] = 0, double: addr[2:0] = 0).
  - Any other combination is illegal.
- Illegal D request:
  - d_gnt = 1 in the same cycle; the RAM is not used.
  - Next cycle: d_err = 1, d_rvalid = 0.
  - The I port may be granted in the same cycle.
- Arbitration, among legal requests, one RAM access per cycle:
  - D only: D wins.
  - I only: I wins.
  - Both: D wins, unless starve_cnt == STARVE_MAX, in which case I wins.
  - The loser sees gnt = 0 and must hold its request stable.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when i_req = 1 and i_gnt = 0.
  - Clears when i_gnt = 1 or i_req = 0.
- Granted access:
  - mem_en = 1, mem_addr = addr[ADDR_W-1:3].
  - Fetches and loads: mem_we = 0.
  - Stores: mem_we = size mask shifted by addr[2:0] (byte 0x01, half 0x03, word 0x0F, double 0xFF).
  - mem_wdata replicates the store data (byte x8, half x4, word x2, double x1).
  - Stores complete at grant; they produce no rvalid.
- Response stage:
  - A registered owner, byte offset and func3 select the mem_rdata lane on the next cycle.
  - I port: i_rdata = mem_rdata[63:32] if addr[2] = 1, otherwise mem_rdata[31:0].
  - D port: the lane is extracted at offset*8; func3 0/1/2 sign-extend, 4/5/6 zero-extend, 3 passes all 64 bits.
  - i_rdata and d_rdata hold their last value when rvalid = 0.
- Throughput and latency:
  - Back-to-back grants on every cycle are allowed.
  - Read latency is exactly 1 cycle; nothing is buffered beyond that one response slot.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants (LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6);
  - a size-to-strobe-mask function;
  - an owner encoding (NONE, I, D).
- Sub-module lsu_align (combinational) holds:
  - legality check;
  - strobe generation;
  - write-data replication;
  - read-lane extract and extend.
- The arbiter keeps the starve counter, grant logic and response registers.

Test Plan:
- Reset release, i_req=1, i_addr=0x0004, mem_rdata=0x11112222_33334444 -> i_gnt same cycle, i_rvalid next cycle, i_rdata=0x11112222.
- d_we=1, func3=0 (SB), d_addr=0x0013, d_wdata=0xAB -> mem_we=0x08, mem_wdata=0xABABABAB_ABABABAB, mem_addr=0x0002, no d_rvalid.
- Load func3=1 (LH), d_addr=0x0006, mem_rdata=0x8001_0000_0000_0000 -> d_rdata=0xFFFF_FFFF_FFFF_8001; repeat with func3=5 (LHU) -> 0x0000_0000_0000_8001.
- i_req and d_req held high for 10 cycles with STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating; i_gnt on cycles 5 and 10.
- LW at d_addr=0x0002 plus i_req in the same cycle -> d_gnt=1 and i_gnt=1, mem_we=0, next cycle d_err=1, d_rvalid=0, i_rvalid=1.
- Reset asserted in the cycle after a granted LD -> d_rvalid stays 0, starve counter reads 0 after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port:
// funct3 codes, response-owner encoding and the access-size strobe helper.
`timescale 1ns/1ps
`default_nettype none

package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Size code is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch/memory stage) and RAM-side signals of the shared memory port.
`timescale 1ns/1ps
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [63:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic [7:0]        mem_we;
  logic [ADDR_W-4:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// Combinational D-side byte-lane logic: legality, store strobes and replication,
// and load-lane extraction with sign/zero extension.
`timescale 1ns/1ps
`default_nettype none

module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [2:0]  req_off,
  input  logic [63:0] req_wdata,
  output logic        req_legal,
  output logic [7:0]  req_strb,
  output logic [63:0] req_wdata_rep,
  input  logic [2:0]  rsp_func3,
  input  logic [2:0]  rsp_off,
  input  logic [63:0] rsp_rdata,
  output logic [63:0] rsp_data
);

  logic [1:0]  req_size;
  logic        aligned;
  logic        func_ok;
  logic [63:0] lane;

  always_comb begin
    req_size = req_func3[1:0];

    case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_off[0];
      2'd2:    aligned = (req_off[1:0] == 2'b00);
      default: aligned = (req_off == 3'b000);
    endcase

    // Stores only have the four signed-size codes; loads reject only 3'b111.
    func_ok   = req_we ? ~req_func3[2] : (req_func3 != 3'd7);
    req_legal = func_ok & aligned;

    req_strb = size_mask(req_size) << req_off;

    case (req_size)
      2'd0:    req_wdata_rep = {8{req_wdata[7:0]}};
      2'd1:    req_wdata_rep = {4{req_wdata[15:0]}};
      2'd2:    req_wdata_rep = {2{req_wdata[31:0]}};
      default: req_wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    lane = rsp_rdata >> {rsp_off, 3'b000};
    case (rsp_func3)
      F3_LB:   rsp_data = {{56{lane[7]}},  lane[7:0]};
      F3_LH:   rsp_data = {{48{lane[15]}}, lane[15:0]};
      F3_LW:   rsp_data = {{32{lane[31]}}, lane[31:0]};
      F3_LD:   rsp_data = lane;
      F3_LBU:  rsp_data = {56'd0, lane[7:0]};
      F3_LHU:  rsp_data = {48'd0, lane[15:0]};
      F3_LWU:  rsp_data = {32'd0, lane[31:0]};
      default: rsp_data = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 64-bit RAM between instruction fetch and load/store,
// with an anti-starvation counter for the fetch side and a one-slot read response.
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic        d_legal;
  logic [7:0]  d_strb;
  logic [63:0] d_wrep;
  logic [63:0] d_rext;

  owner_e            owner_q,  owner_d;
  logic [2:0]        off_q,    off_d;
  logic [2:0]        func3_q,  func3_d;
  logic              err_q,    err_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [31:0]       i_hold_q, i_hold_d;
  logic [63:0]       d_hold_q, d_hold_d;

  logic        i_win;
  logic        d_win;
  logic        d_illegal;
  logic [31:0] i_lane;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[1:0];

  lsu_align u_align (
    .req_we        (bus.d_we),
    .req_func3     (bus.d_func3),
    .req_off       (bus.d_addr[2:0]),
    .req_wdata     (bus.d_wdata),
    .req_legal     (d_legal),
    .req_strb      (d_strb),
    .req_wdata_rep (d_wrep),
    .rsp_func3     (func3_q),
    .rsp_off       (off_q),
    .rsp_rdata     (bus.mem_rdata),
    .rsp_data      (d_rext)
  );

  // Grant and RAM-request side.
  always_comb begin
    d_illegal = bus.d_req & ~d_legal;
    i_win     = bus.i_req & (~(bus.d_req & d_legal) | (starve_q == CNT_MAX));
    d_win     = bus.d_req & d_legal & ~i_win;

    bus.i_gnt     = reset & i_win;
    bus.d_gnt     = reset & (d_win | d_illegal);
    bus.mem_en    = reset & (i_win | d_win);
    bus.mem_we    = (reset & d_win & bus.d_we) ? d_strb : 8'h00;
    bus.mem_addr  = i_win ? bus.i_addr[ADDR_W-1:3] : bus.d_addr[ADDR_W-1:3];
    bus.mem_wdata = d_wrep;

    if (bus.i_req && !i_win) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Response slot bookkeeping for the next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    off_d   = off_q;
    func3_d = func3_q;
    err_d   = d_illegal;
    if (i_win) begin
      owner_d = OWN_I;
      off_d   = {bus.i_addr[2], 2'b00};
    end else if (d_win && !bus.d_we) begin
      owner_d = OWN_D;
      off_d   = bus.d_addr[2:0];
      func3_d = bus.d_func3;
    end
  end

  // Read data is live while valid and otherwise holds the last delivered value.
  always_comb begin
    i_lane       = off_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
    bus.i_rvalid = (owner_q == OWN_I);
    bus.d_rvalid = (owner_q == OWN_D);
    bus.d_err    = err_q;
    bus.i_rdata  = bus.i_rvalid ? i_lane : i_hold_q;
    bus.d_rdata  = bus.d_rvalid ? d_rext : d_hold_q;
    i_hold_d     = bus.i_rdata;
    d_hold_d     = bus.d_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OWN_NONE;
      off_q    <= 3'd0;
      func3_q  <= 3'd0;
      err_q    <= 1'b0;
      starve_q <= '0;
      i_hold_q <= 32'd0;
      d_hold_q <= 64'd0;
    end else begin
      owner_q  <= owner_d;
      off_q    <= off_d;
      func3_q  <= func3_d;
      err_q    <= err_d;
      starve_q <= starve_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

endmodule

`default_nettype wire
